// File: rtl/star_port_arbiter.sv
// rtl/star_port_arbiter.sv - wormhole round-robin arbiter for one router output port
module star_port_arbiter #(
    parameter int NUM_IN = 4,
    parameter int FLIT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*FLIT_W-1:0] flit_in,
    output logic [NUM_IN-1:0]        gnt,
    input  logic                     out_ready,
    output logic [FLIT_W-1:0]        flit_out,
    output logic                     valid_out,
    output logic                     busy,
    output logic [2:0]               owner,
    output logic                     proto_err,
    output logic [7:0]               pkt_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] TY_BODY   = 2'b00;
    localparam logic [1:0] TY_TAIL   = 2'b01;
    localparam logic [1:0] TY_HDR    = 2'b10;
    localparam logic [1:0] TY_SINGLE = 2'b11;

    // Flit type lives in the two top bits of every flit
    function automatic logic [1:0] type_of(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1 -: 2];
    endfunction

    // Registered state
    logic [0:0]        r_state;
    logic [2:0]        r_owner;
    logic [2:0]        r_rr_ptr;
    logic              r_first;      // next transfer of the open packet is its own header
    logic [FLIT_W-1:0] r_flit_out;
    logic              r_valid_out;
    logic              r_proto_err;
    logic [7:0]        r_pkt_cnt;

    // Combinational helpers
    logic [NUM_IN-1:0] w_is_start;   // flit opens a packet (HDR or SINGLE)
    logic [NUM_IN-1:0] w_is_mid;     // flit continues a packet (BODY or TAIL)
    logic [NUM_IN-1:0] w_cand;
    logic [NUM_IN-1:0] w_rot;
    logic              w_win_found;
    logic [3:0]        w_win_off;
    logic [3:0]        w_win_sum;
    logic [2:0]        w_winner;
    logic              w_owner_req;
    logic [FLIT_W-1:0] w_owner_flit;
    logic [1:0]        w_owner_type;
    logic              w_xfer;
    logic              w_pkt_end;
    logic              w_idle_err;
    logic              w_hdr_err;
    logic [2:0]        w_rr_next;

    // Decode the type of every presented flit
    always_comb begin
        w_is_start = '0;
        w_is_mid   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_is_start[i] = (type_of(flit_in[i*FLIT_W +: FLIT_W]) == TY_HDR) ||
                            (type_of(flit_in[i*FLIT_W +: FLIT_W]) == TY_SINGLE);
            w_is_mid[i]   = (type_of(flit_in[i*FLIT_W +: FLIT_W]) == TY_BODY) ||
                            (type_of(flit_in[i*FLIT_W +: FLIT_W]) == TY_TAIL);
        end
    end

    assign w_cand = req & w_is_start;

    // Rotate candidates so that bit 0 is the input at rr_ptr; the first set bit is the winner
    assign w_rot = NUM_IN'({w_cand, w_cand} >> r_rr_ptr);

    // Find the lowest set bit of the rotated candidate vector
    always_comb begin
        w_win_found = 1'b0;
        w_win_off   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_win_found = 1'b1;
                w_win_off   = 4'(i);
            end
        end
    end

    // Undo the rotation: winner = (rr_ptr + offset) mod NUM_IN
    assign w_win_sum = {1'b0, r_rr_ptr} + w_win_off;
    assign w_winner  = (w_win_sum >= 4'(NUM_IN)) ? 3'(w_win_sum - 4'(NUM_IN)) : 3'(w_win_sum);

    // Select the request and flit of the input holding the port
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_owner == 3'(i)) begin
                w_owner_req  = req[i];
                w_owner_flit = flit_in[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign w_owner_type = type_of(w_owner_flit);

    // A flit moves when the owner offers one and the output register is free or draining
    assign w_xfer    = !rst && (r_state == ST_BUSY) && w_owner_req && (!r_valid_out || out_ready);
    assign w_pkt_end = (w_owner_type == TY_TAIL) || (w_owner_type == TY_SINGLE);
    assign w_rr_next = (r_owner == 3'(NUM_IN - 1)) ? 3'd0 : r_owner + 3'd1;

    // Continuation flits offered while nobody owns the port are illegal
    assign w_idle_err = (r_state == ST_IDLE) && |(req & w_is_mid);
    // A header after the packet's own header means the source skipped its tail
    assign w_hdr_err  = w_xfer && (w_owner_type == TY_HDR) && !r_first;

    // One-hot pop strobe towards the owner on every transfer
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            gnt[i] = w_xfer && (r_owner == 3'(i));
        end
    end

    // Arbitration FSM: IDLE picks a winner, BUSY holds the port until a tail passes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_first  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_win_found) begin
                r_state <= ST_BUSY;
                r_owner <= w_winner;
                r_first <= 1'b1;
            end
        end else if (w_xfer) begin
            r_first <= 1'b0;
            if (w_pkt_end) begin
                r_state  <= ST_IDLE;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // Output register: load on transfer, drain when downstream takes it, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flit_out  <= '0;
            r_valid_out <= 1'b0;
        end else if (w_xfer) begin
            r_flit_out  <= w_owner_flit;
            r_valid_out <= 1'b1;
        end else if (out_ready) begin
            r_valid_out <= 1'b0;
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (w_idle_err || w_hdr_err) begin
            r_proto_err <= 1'b1;
        end
    end

    // Completed packet counter, wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else if (w_xfer && w_pkt_end) begin
            r_pkt_cnt <= r_pkt_cnt + 8'd1;
        end
    end

    assign flit_out  = r_flit_out;
    assign valid_out = r_valid_out;
    assign busy      = (r_state == ST_BUSY);
    assign owner     = r_owner;
    assign proto_err = r_proto_err;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_star_port_arbiter.sv
// tb/tb_star_port_arbiter.sv - self-checking bench for star_port_arbiter
module tb_star_port_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b01;
    localparam logic [1:0] T_HDR  = 2'b10;
    localparam logic [1:0] T_SGL  = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] flit_in = '0;
    logic           out_ready = 1'b0;
    logic [N-1:0]   gnt;
    logic [W-1:0]   flit_out;
    logic           valid_out;
    logic           busy;
    logic [2:0]     owner;
    logic           proto_err;
    logic [7:0]     pkt_cnt;

    star_port_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_in(flit_in), .gnt(gnt),
        .out_ready(out_ready), .flit_out(flit_out), .valid_out(valid_out),
        .busy(busy), .owner(owner), .proto_err(proto_err), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source queues (what each input presents) and scoreboard queues (what must come out)
    logic [W-1:0] src_q [N][$];
    logic [W-1:0] exp_q [N][$];
    int           owners [$];
    int           n_deliv = 0;
    int           n_gnts  = 0;
    logic [9:0]   pay_ctr = '0;

    // Reference model: packet-level view of the port
    bit           m_busy;
    int           m_owner, m_rr, m_cnt, m_nfl;
    bit           m_vo, m_err;
    logic [W-1:0] m_fo;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_nfl = 0;
        m_vo = 0; m_err = 0; m_fo = '0;
    endtask

    task automatic push_flit(input int i, input logic [1:0] ty, input bit to_exp);
        logic [W-1:0] f;
        f = {ty, pay_ctr, 4'(i)};
        pay_ctr++;
        src_q[i].push_back(f);
        if (to_exp) exp_q[i].push_back(f);
    endtask

    task automatic load_pkt(input int i, input int len);
        if (len == 1) begin
            push_flit(i, T_SGL, 1);
        end else begin
            push_flit(i, T_HDR, 1);
            for (int k = 0; k < len - 2; k++) push_flit(i, T_BODY, 1);
            push_flit(i, T_TAIL, 1);
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1; req = '0; flit_in = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        owners.delete();
    endtask

    // One clock: drive from source queues, compare against the model, advance the model
    task automatic cycle(input logic r, input logic rdy, input logic [N-1:0] mask);
        logic [N-1:0] eg;
        logic [W-1:0] f;
        int           idx;
        bit           was_busy;
        rst = r;
        out_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req[i] = mask[i] && (src_q[i].size() > 0);
            flit_in[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        @(negedge clk);
        eg = '0;
        if (!r && m_busy && req[m_owner] && (!m_vo || rdy)) eg[m_owner] = 1'b1;
        chk("gnt", gnt, eg);
        chk("valid_out", valid_out, m_vo);
        chk("flit_out", flit_out, m_fo);
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("pkt_cnt", pkt_cnt, m_cnt);
        chk("proto_err", proto_err, m_err);
        if (valid_out && rdy) begin
            n_deliv++;
            idx = int'(flit_out[3:0]);
            if (idx >= N || exp_q[idx].size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL delivered flit: got %0h expected no pending flit", flit_out);
            end else begin
                chk("delivered flit", flit_out, exp_q[idx].pop_front());
            end
        end
        if (gnt != '0) begin
            n_gnts++;
            owners.push_back(int'(owner));
        end
        for (int i = 0; i < N; i++)
            if (gnt[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        was_busy = m_busy;
        if (r) begin
            model_reset();
        end else begin
            if (eg != '0) begin
                f = flit_in[m_owner*W +: W];
                m_fo = f;
                m_vo = 1;
                if (f[W-1 -: 2] == T_HDR && m_nfl > 0) m_err = 1;
                m_nfl++;
                if (f[W-1 -: 2] == T_TAIL || f[W-1 -: 2] == T_SGL) begin
                    m_busy = 0;
                    m_rr = (m_owner + 1) % N;
                    m_cnt = (m_cnt + 1) % 256;
                end
            end else if (rdy) begin
                m_vo = 0;
            end
            if (!was_busy) begin
                for (int i = 0; i < N; i++)
                    if (req[i] && (flit_in[i*W + W-1 -: 2] == T_BODY || flit_in[i*W + W-1 -: 2] == T_TAIL))
                        m_err = 1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (!m_busy && req[idx] &&
                        (flit_in[idx*W + W-1 -: 2] == T_HDR || flit_in[idx*W + W-1 -: 2] == T_SGL)) begin
                        m_busy = 1;
                        m_owner = idx;
                        m_nfl = 0;
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*W-1:0] fl;
        logic           rdy;
        logic [N-1:0]   g;
        logic           v;
        logic [W-1:0]   fo;
        logic           b;
        logic [2:0]     o;
        logic [7:0]     c;
        logic           e;
    } vec_t;

    function automatic logic [N*W-1:0] at(input int i, input logic [W-1:0] f);
        logic [N*W-1:0] v;
        v = '0;
        v[i*W +: W] = f;
        return v;
    endfunction

    function automatic vec_t row(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] fl,
                                 input logic [N-1:0] g, input logic v, input logic [W-1:0] fo,
                                 input logic b, input logic [2:0] o, input logic [7:0] c);
        vec_t x;
        x = '{rst: r, req: rq, fl: fl, rdy: 1'b1, g: g, v: v, fo: fo, b: b, o: o, c: c, e: 1'b0};
        return x;
    endfunction

    vec_t tbl [15];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] h2, b2a, b2b, t2, h0, t0, s3;
        int           mism, rem, base;
        h2 = 16'h8012; b2a = 16'h0022; b2b = 16'h0032; t2 = 16'h4042;
        h0 = 16'h8050; t0 = 16'h4060; s3 = 16'hC073;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single packet on input 2, then reset, then contention between inputs 0 and 3
        tbl[0]  = row(0, 4'b0000, '0,                      4'b0000, 0, 16'h0, 0, 3'd0, 8'd0);
        tbl[1]  = row(0, 4'b0100, at(2, h2),               4'b0000, 0, 16'h0, 0, 3'd0, 8'd0);
        tbl[2]  = row(0, 4'b0100, at(2, h2),               4'b0100, 0, 16'h0, 1, 3'd2, 8'd0);
        tbl[3]  = row(0, 4'b0100, at(2, b2a),              4'b0100, 1, h2,    1, 3'd2, 8'd0);
        tbl[4]  = row(0, 4'b0100, at(2, b2b),              4'b0100, 1, b2a,   1, 3'd2, 8'd0);
        tbl[5]  = row(0, 4'b0100, at(2, t2),               4'b0100, 1, b2b,   1, 3'd2, 8'd0);
        tbl[6]  = row(0, 4'b0000, '0,                      4'b0000, 1, t2,    0, 3'd2, 8'd1);
        tbl[7]  = row(0, 4'b0000, '0,                      4'b0000, 0, t2,    0, 3'd2, 8'd1);
        tbl[8]  = row(1, 4'b0000, '0,                      4'b0000, 0, t2,    0, 3'd2, 8'd1);
        tbl[9]  = row(0, 4'b1001, at(0, h0) | at(3, s3),   4'b0000, 0, 16'h0, 0, 3'd0, 8'd0);
        tbl[10] = row(0, 4'b1001, at(0, h0) | at(3, s3),   4'b0001, 0, 16'h0, 1, 3'd0, 8'd0);
        tbl[11] = row(0, 4'b1001, at(0, t0) | at(3, s3),   4'b0001, 1, h0,    1, 3'd0, 8'd0);
        tbl[12] = row(0, 4'b1000, at(3, s3),               4'b0000, 1, t0,    0, 3'd0, 8'd1);
        tbl[13] = row(0, 4'b1000, at(3, s3),               4'b1000, 0, t0,    1, 3'd3, 8'd1);
        tbl[14] = row(0, 4'b0000, '0,                      4'b0000, 1, s3,    0, 3'd3, 8'd2);

        for (int k = 0; k < 15; k++) begin
            rst = tbl[k].rst; req = tbl[k].req; flit_in = tbl[k].fl; out_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d gnt", k), gnt, tbl[k].g);
            chk($sformatf("vec%0d valid_out", k), valid_out, tbl[k].v);
            if (tbl[k].v) chk($sformatf("vec%0d flit_out", k), flit_out, tbl[k].fo);
            chk($sformatf("vec%0d busy", k), busy, tbl[k].b);
            if (tbl[k].b) chk($sformatf("vec%0d owner", k), owner, tbl[k].o);
            chk($sformatf("vec%0d pkt_cnt", k), pkt_cnt, tbl[k].c);
            chk($sformatf("vec%0d proto_err", k), proto_err, tbl[k].e);
            @(posedge clk); #1;
        end

        // Backpressure: out_ready low for three cycles in the middle of a 5-flit packet
        hard_reset();
        base = n_deliv;
        load_pkt(1, 5);
        for (int c = 0; c < 14; c++) cycle(0, !(c >= 4 && c <= 6), 4'b1111);
        chk("backpressure flits delivered", n_deliv - base, 5);
        chk("backpressure flits pending", exp_q[1].size(), 0);

        // Errors: continuation flit in IDLE, then a second header inside a packet
        hard_reset();
        push_flit(1, T_BODY, 0);
        cycle(0, 1, 4'b0010);
        cycle(0, 1, 4'b0010);
        chk("body in idle sets proto_err", proto_err, 1);
        hard_reset();
        chk("proto_err cleared by reset", proto_err, 0);
        push_flit(2, T_HDR, 1);
        push_flit(2, T_BODY, 1);
        push_flit(2, T_HDR, 1);
        push_flit(2, T_TAIL, 1);
        for (int c = 0; c < 8; c++) cycle(0, 1, 4'b1111);
        chk("early header sets proto_err", proto_err, 1);
        chk("early header packet forwarded", exp_q[2].size(), 0);

        // Reset in the middle of a packet, with rr_ptr moved away from 0 beforehand
        hard_reset();
        load_pkt(1, 1);
        for (int c = 0; c < 3; c++) cycle(0, 1, 4'b1111);
        load_pkt(0, 5);
        base = n_gnts;
        for (int c = 0; c < 20 && (n_gnts - base) < 2; c++) cycle(0, 1, 4'b1111);
        cycle(1, 0, 4'b0000);
        src_q[0].delete();
        exp_q[0].delete();
        chk("mid-packet reset busy", busy, 0);
        chk("mid-packet reset valid_out", valid_out, 0);
        owners.delete();
        load_pkt(1, 1);
        load_pkt(3, 1);
        for (int c = 0; c < 8; c++) cycle(0, 1, 4'b1111);
        chk("post-reset first owner", (owners.size() > 0) ? owners[0] : 99, 1);
        chk("post-reset pkt_cnt", pkt_cnt, 2);
        chk("post-reset proto_err", proto_err, 0);

        // Wrap: 256 SINGLE packets with every input requesting continuously
        hard_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 256 / N; k++) load_pkt(i, 1);
        for (int c = 0; c < 1200; c++) begin
            rem = 0;
            for (int i = 0; i < N; i++) rem += src_q[i].size();
            if (rem == 0 && !valid_out) break;
            cycle(0, 1, 4'b1111);
        end
        chk("wrap grant count", owners.size(), 256);
        mism = 0;
        for (int k = 0; k < owners.size(); k++) if (owners[k] != k % N) mism++;
        chk("wrap round-robin order mismatches", mism, 0);
        chk("wrap pkt_cnt", pkt_cnt, 0);

        // Randomized traffic with random request gaps and backpressure
        hard_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) load_pkt(i, int'($urandom_range(1, 5)));
        for (int c = 0; c < 4000; c++) begin
            rem = 0;
            for (int i = 0; i < N; i++) rem += src_q[i].size();
            if (rem == 0 && !valid_out) break;
            cycle(0, ($urandom % 4) != 0, N'($urandom));
        end
        rem = 0;
        for (int i = 0; i < N; i++) rem += exp_q[i].size();
        chk("random flits left undelivered", rem, 0);
        chk("random pkt_cnt", pkt_cnt, 6 * N);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
